// File: rtl/haar_pkg.sv
// Shared constants, weight struct and corner-sign helper for the Haar feature evaluator.
package haar_pkg;

    localparam int POINT_CNT = 12;
    localparam int RECT_CNT  = 3;

    typedef struct packed {
        logic [1:0] w1;
        logic [1:0] w2;
    } haar_weight_t;

    // Corners 0..3 contribute +,-,+,- : returns 1 when the corner is subtracted.
    function automatic logic corner_sign(input logic [1:0] corner);
        return corner[0];
    endfunction

endpackage

// File: rtl/ii_rd_align.sv
// Delays the point valid and its 4-bit index so they line up with ram_ii read data.
module ii_rd_align #(
    parameter int DEPTH = 1,
    parameter int TAG_W = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             val_i,
    input  logic [TAG_W-1:0] tag_i,
    output logic             val_o,
    output logic [TAG_W-1:0] tag_o
);

    logic [DEPTH-1:0] val_q;
    logic [TAG_W-1:0] tag_q [DEPTH];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            val_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            val_q[0] <= val_i;
            tag_q[0] <= tag_i;
            for (int i = 1; i < DEPTH; i++) begin
                val_q[i] <= val_q[i-1];
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    assign val_o = val_q[DEPTH-1];
    assign tag_o = tag_q[DEPTH-1];

endmodule

// File: rtl/haar_feature_eval.sv
// Haar feature evaluator: issues ram_ii reads, accumulates rect sums, weights them and votes.
// Build option HAAR_EVAL_SAT_EN: saturate the feature sum to THR_WIDTH instead of wrapping.
module haar_feature_eval
    import haar_pkg::*;
#(
    parameter int ADDR_WIDTH  = 30,
    parameter int DATA_WIDTH  = 18,
    parameter int RAM_LATENCY = 1,
    parameter int THR_WIDTH   = 24
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  val_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [3:0]            num_point_i,
    input  logic [3:0]            weight_i,
    input  logic [THR_WIDTH-1:0]  threshold_i,
    output logic                  ram_rd_en_o,
    output logic [ADDR_WIDTH-1:0] ram_rd_addr_o,
    input  logic [DATA_WIDTH-1:0] ram_rd_data_i,
    output logic                  busy_o,
    output logic                  result_val_o,
    output logic [THR_WIDTH-1:0]  feature_sum_o,
    output logic                  vote_o,
    output logic                  seq_err_o
);

`ifdef HAAR_EVAL_SAT_EN
    localparam int ACC_W = DATA_WIDTH + 5;
`else
    localparam int ACC_W = DATA_WIDTH + 2;
`endif
    localparam int FULL_W = DATA_WIDTH + 5;
    localparam int WIDE_W = ((FULL_W > THR_WIDTH) ? FULL_W : THR_WIDTH) + 1;
    localparam logic [3:0] LAST_IDX = 4'(POINT_CNT - 1);

    assign ram_rd_en_o   = val_i;
    assign ram_rd_addr_o = addr_i;

    logic       al_val;
    logic [3:0] al_idx;

    ii_rd_align #(
        .DEPTH (RAM_LATENCY),
        .TAG_W (4)
    ) u_align (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .val_i (val_i),
        .tag_i (num_point_i),
        .val_o (al_val),
        .tag_o (al_idx)
    );

    // Weight/threshold are only valid alongside input point 0; hold them until it aligns.
    haar_weight_t                 in_w_q;
    logic signed [THR_WIDTH-1:0]  in_thr_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            in_w_q   <= '0;
            in_thr_q <= '0;
        end else if (val_i && (num_point_i == 4'd0)) begin
            in_w_q   <= haar_weight_t'(weight_i);
            in_thr_q <= threshold_i;
        end
    end

    logic signed [ACC_W-1:0]     acc_q [RECT_CNT];
    logic signed [ACC_W-1:0]     acc_d [RECT_CNT];
    logic [3:0]                  exp_idx_q, exp_idx_d;
    logic                        collect_q, collect_d;
    logic                        done_q, done_d;
    logic                        seq_err_d;
    logic                        take;
    haar_weight_t                feat_w_q, feat_w_d;
    logic signed [THR_WIDTH-1:0] feat_thr_q, feat_thr_d;
    logic signed [ACC_W-1:0]     data_ext;

    assign data_ext = $signed({{(ACC_W-DATA_WIDTH){1'b0}}, ram_rd_data_i});

    always_comb begin
        acc_d      = acc_q;
        exp_idx_d  = exp_idx_q;
        collect_d  = collect_q;
        feat_w_d   = feat_w_q;
        feat_thr_d = feat_thr_q;
        done_d     = 1'b0;
        seq_err_d  = 1'b0;
        take       = 1'b0;
        if (al_val) begin
            if (al_idx == 4'd0) begin
                // Point 0 always (re)starts a feature, silently discarding any partial one.
                for (int r = 0; r < RECT_CNT; r++) begin
                    acc_d[r] = '0;
                end
                collect_d  = 1'b1;
                exp_idx_d  = 4'd1;
                feat_w_d   = in_w_q;
                feat_thr_d = in_thr_q;
                take       = 1'b1;
            end else if (collect_q) begin
                if (al_idx == exp_idx_q) begin
                    take = 1'b1;
                    if (al_idx == LAST_IDX) begin
                        collect_d = 1'b0;
                        done_d    = 1'b1;
                    end else begin
                        exp_idx_d = exp_idx_q + 4'd1;
                    end
                end else begin
                    collect_d = 1'b0;
                    seq_err_d = 1'b1;
                end
            end
        end
        if (take) begin
            for (int r = 0; r < RECT_CNT; r++) begin
                if (al_idx[3:2] == 2'(r)) begin
                    acc_d[r] = corner_sign(al_idx[1:0]) ? (acc_d[r] - data_ext)
                                                        : (acc_d[r] + data_ext);
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int r = 0; r < RECT_CNT; r++) begin
                acc_q[r] <= '0;
            end
            exp_idx_q  <= '0;
            collect_q  <= 1'b0;
            done_q     <= 1'b0;
            feat_w_q   <= '0;
            feat_thr_q <= '0;
        end else begin
            acc_q      <= acc_d;
            exp_idx_q  <= exp_idx_d;
            collect_q  <= collect_d;
            done_q     <= done_d;
            feat_w_q   <= feat_w_d;
            feat_thr_q <= feat_thr_d;
        end
    end

    // F-stage copies are separate so the next feature's point 0 can overlap the compare.
    haar_weight_t                f_w_q;
    logic signed [THR_WIDTH-1:0] f_thr_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            f_w_q   <= '0;
            f_thr_q <= '0;
        end else if (done_d) begin
            f_w_q   <= feat_w_q;
            f_thr_q <= feat_thr_q;
        end
    end

    logic signed [WIDE_W-1:0]    acc_w [RECT_CNT];
    logic signed [WIDE_W-1:0]    w1_w, w2_w, f_wide;
    logic signed [THR_WIDTH-1:0] f_fit;

    always_comb begin
        for (int r = 0; r < RECT_CNT; r++) begin
            acc_w[r] = {{(WIDE_W-ACC_W){acc_q[r][ACC_W-1]}}, acc_q[r]};
        end
        w1_w   = {{(WIDE_W-2){1'b0}}, f_w_q.w1};
        w2_w   = {{(WIDE_W-2){1'b0}}, f_w_q.w2};
        f_wide = (w1_w * acc_w[1]) + (w2_w * acc_w[2]) - acc_w[0];
    end

`ifdef HAAR_EVAL_SAT_EN
    localparam logic signed [WIDE_W-1:0] F_MAX =
        $signed({{(WIDE_W-THR_WIDTH+1){1'b0}}, {(THR_WIDTH-1){1'b1}}});
    localparam logic signed [WIDE_W-1:0] F_MIN =
        $signed({{(WIDE_W-THR_WIDTH+1){1'b1}}, {(THR_WIDTH-1){1'b0}}});

    always_comb begin
        if (f_wide > F_MAX) begin
            f_fit = F_MAX[THR_WIDTH-1:0];
        end else if (f_wide < F_MIN) begin
            f_fit = F_MIN[THR_WIDTH-1:0];
        end else begin
            f_fit = f_wide[THR_WIDTH-1:0];
        end
    end
`else
    logic unused_f_hi;

    assign f_fit       = f_wide[THR_WIDTH-1:0];
    assign unused_f_hi = ^f_wide[WIDE_W-1:THR_WIDTH];
`endif

    logic                 res_val_q;
    logic [THR_WIDTH-1:0] sum_q;
    logic                 vote_q;
    logic                 seq_err_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            res_val_q <= 1'b0;
            sum_q     <= '0;
            vote_q    <= 1'b0;
            seq_err_q <= 1'b0;
        end else begin
            res_val_q <= done_q;
            seq_err_q <= seq_err_d;
            if (done_q) begin
                sum_q  <= f_fit;
                vote_q <= (f_fit >= f_thr_q);
            end
        end
    end

    assign busy_o        = collect_q | done_q;
    assign result_val_o  = res_val_q;
    assign feature_sum_o = sum_q;
    assign vote_o        = vote_q;
    assign seq_err_o     = seq_err_q;

endmodule
